// File: rtl/riscv_pkg.sv
// Shared RISC-V fetch definitions: datapath width, reset/NOP defaults and the
// fetch FSM state type.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INST_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and instruction memory (slave).
interface fetch_unit_if
    import riscv_pkg::*;
();

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_pc_next.sv
// Combinational next-PC selection (PC+4 or JALR-style ALU target).
// Build option: FETCH_MISALIGN_CHK_EN keeps next_pc[1] so the fetch unit can trap on it.
module fetch_pc_next
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic            pc_sel,
    input  logic [XLEN-1:0] alu_out,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] next_pc
);

    logic [XLEN-1:0] target;

    // Addition wraps naturally at 2^32.
    assign pc_plus4 = pc + 32'd4;
    assign target   = pc_sel ? (alu_out & ~32'h0000_0001) : pc_plus4;

`ifdef FETCH_MISALIGN_CHK_EN
    assign next_pc = target;
`else
    // Without the checker a half-word target is silently word-aligned.
    assign next_pc = target & ~32'h0000_0003;
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one word at PC, holds it for the core until ack.
// Build option: FETCH_MISALIGN_CHK_EN enables the sticky misalignment trap (HALT state).
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    fetch_unit_if.master    imem,
    input  logic            PCSel,
    input  logic [XLEN-1:0] ALU_out,
    input  logic            inst_ack,
    output logic [XLEN-1:0] inst,
    output logic            inst_valid,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PC4,
    output logic            misalign_err
);

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic [XLEN-1:0] next_pc;
    logic            load_inst;
    logic            advance;
`ifdef FETCH_MISALIGN_CHK_EN
    logic            enter_halt;
`endif

    fetch_pc_next u_pc_next (
        .pc       (PC),
        .pc_sel   (PCSel),
        .alu_out  (ALU_out),
        .pc_plus4 (PC4),
        .next_pc  (next_pc)
    );

    assign imem.imem_req  = (state_q == ST_REQ) && !rst;
    assign imem.imem_addr = PC;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // rvalid only matters in REQ (together with ready) and in WAIT; ack only in HOLD.
    always_comb begin
        state_d    = state_q;
        load_inst  = 1'b0;
        advance    = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        enter_halt = 1'b0;
`endif
        case (state_q)
            ST_REQ: begin
                if (imem.imem_ready) begin
                    if (imem.imem_rvalid) begin
                        load_inst = 1'b1;
                        state_d   = ST_HOLD;
                    end else begin
                        state_d   = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (imem.imem_rvalid) begin
                    load_inst = 1'b1;
                    state_d   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (inst_ack) begin
`ifdef FETCH_MISALIGN_CHK_EN
                    if (next_pc[1]) begin
                        enter_halt = 1'b1;
                        state_d    = ST_HALT;
                    end else begin
                        advance    = 1'b1;
                        state_d    = ST_REQ;
                    end
`else
                    advance = 1'b1;
                    state_d = ST_REQ;
`endif
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            PC         <= RESET_PC;
            inst       <= NOP_INST;
            inst_valid <= 1'b0;
        end else if (load_inst) begin
            inst       <= imem.imem_rdata;
            inst_valid <= 1'b1;
        end else if (advance) begin
            PC         <= next_pc;
            inst       <= NOP_INST;
            inst_valid <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        end else if (enter_halt) begin
            inst       <= NOP_INST;
            inst_valid <= 1'b0;
`endif
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_err <= 1'b0;
        end else if (enter_halt) begin
            misalign_err <= 1'b1;
        end
    end
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC value loaded on reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0), SHALL set the inst value presented while no fetched word is valid.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 PCSel  input  1  from Control_Unit; 1 selects ALU_out as next PC, 0 selects PC+4.
REQ-006 ALU_out  input  32  branch/jump target computed by the ALU.
REQ-007 inst_ack  input  1  core has consumed the current inst; advance the PC.
REQ-008 imem_req  output  1  instruction memory request valid.
REQ-009 imem_addr  output  32  instruction memory word address (byte address, bits[1:0]=00).
REQ-010 imem_ready  input  1  memory accepts the request this cycle.
REQ-011 imem_rvalid  input  1  imem_rdata valid this cycle.
REQ-012 imem_rdata  input  32  fetched instruction word.
REQ-013 inst  output  32  instruction to Control_Unit and decode (registered).
REQ-014 inst_valid  output  1  inst holds a fetched word for PC.
REQ-015 PC  output  32  address of the current inst (registered).
REQ-016 PC4  output  32  PC+4, combinational from PC, for the JAL/JALR writeback path.
REQ-017 misalign_err  output  1  sticky fetch-target misalignment flag.

Function
REQ-018 The FSM SHALL have states REQ, WAIT, HOLD and HALT.
REQ-019 In REQ: imem_req=1, imem_addr=PC; imem_ready=1 with imem_rvalid=0 SHALL go to WAIT; imem_ready=1 with imem_rvalid=1 in the same cycle SHALL capture imem_rdata and go to HOLD (zero-wait memory).
REQ-020 imem_rvalid SHALL be ignored in REQ unless imem_ready=1 in the same cycle, and SHALL always be ignored in HOLD and HALT.
REQ-021 In WAIT: imem_req=0; imem_rvalid=1 SHALL capture inst<=imem_rdata, set inst_valid=1 and go to HOLD; otherwise stay in WAIT indefinitely.
REQ-022 In HOLD: inst and PC SHALL stay stable and inst_valid=1 until inst_ack=1.
REQ-023 On inst_ack=1 in HOLD, the unit SHALL load PC<=next_pc, clear inst_valid, set inst<=NOP_INST and go to REQ in the same edge.
REQ-024 next_pc SHALL be {ALU_out[31:1],1'b0} when PCSel=1 (JALR LSB clear), else PC+4.
REQ-025 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-026 inst_ack outside HOLD SHALL be ignored.
REQ-027 Minimum latency: request to inst_valid is 1 cycle; inst_ack to the next imem_req is 1 cycle.

Reset
REQ-028 On rst=1 at an edge: PC<=RESET_PC, inst<=NOP_INST, inst_valid<=0, misalign_err<=0, state<=REQ; rst SHALL override all other inputs.
REQ-029 Reset in WAIT or HOLD SHALL abandon the outstanding fetch; instruction memory SHALL share the same rst, so no stale imem_rvalid follows.
REQ-030 imem_req SHALL be 0 during any cycle with rst=1.

Configuration
REQ-031 Macro FETCH_MISALIGN_CHK_EN defined: on inst_ack with next_pc[1]=1, set misalign_err=1, leave PC unchanged and enter HALT (imem_req=0, inst_valid=0); only rst leaves HALT.
REQ-032 Macro undefined: next_pc[1:0] SHALL be forced to 00, misalign_err SHALL be tied 0 and HALT SHALL be unreachable.

Structure
REQ-033 Package riscv_pkg SHALL hold XLEN=32, the RESET_PC and NOP_INST default constants, and the fetch state enum.
REQ-034 Next-PC selection and PC+4 SHALL sit in one combinational sub-module, fetch_pc_next; the FSM and registers SHALL stay in fetch_unit.

Verification
REQ-035 Reset release, memory ready=1 and rvalid=1 every cycle, ack every HOLD -> imem_addr 0,4,8,...; inst_valid rises 1 cycle after each request.
REQ-036 Ready at cycle 0, rvalid delayed 3 cycles -> WAIT held 3 cycles, imem_req=0 in WAIT, inst equals rdata only after rvalid.
REQ-037 PC=0x100, PCSel=1, ALU_out=0x205 (macro off) -> next imem_addr 0x204; PC=0xFFFF_FFFC with PCSel=0 -> next imem_addr 0x0.
REQ-038 Macro on, PCSel=1, ALU_out=0x0000_0402 at ack -> misalign_err=1, HALT, PC unchanged, no further imem_req until rst.
REQ-039 rst asserted in WAIT -> next cycle PC=RESET_PC, inst=0x0000_0013, inst_valid=0, state REQ with imem_req=1.
REQ-040 inst_ack pulsed in REQ/WAIT and imem_rvalid pulsed in HOLD -> no PC change, inst unchanged.
